// File: rtl/fpu_cg_sequencer.sv
// Per-unit clock-gate sequencer: idle hysteresis before cutting a unit's clock,
// fixed wake-up delay after restoring it, and a ready flag for the arbiter.
module fpu_cg_sequencer #(
    parameter int NB_UNITS    = 5,
    parameter int CNT_WIDTH   = 4,
    parameter int WAKE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bypass_i,
    input  logic [CNT_WIDTH-1:0] idle_timeout_i,
    input  logic [NB_UNITS-1:0]  cg_enable_i,
    output logic [NB_UNITS-1:0]  clk_en_o,
    output logic [NB_UNITS-1:0]  unit_ready_o,
    output logic [NB_UNITS-1:0]  unit_gated_o
);

    localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;
    localparam logic [WCNT_W-1:0] WAKE_LAST =
        WCNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        OFF  = 2'd1,
        WAKE = 2'd2
    } state_e;

    logic [NB_UNITS-1:0] act;

    assign act = cg_enable_i | {NB_UNITS{bypass_i}};

    for (genvar g = 0; g < NB_UNITS; g++) begin : g_unit
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [WCNT_W-1:0]    wcnt_q, wcnt_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= RUN;
                cnt_q   <= '0;
                wcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wcnt_q  <= wcnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wcnt_d  = wcnt_q;
            case (state_q)
                RUN: begin
                    // Activity wins over an expired count; >= tolerates T dropping mid-count.
                    if (act[g]) begin
                        cnt_d = '0;
                    end else if (cnt_q >= idle_timeout_i) begin
                        state_d = OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OFF: begin
                    if (act[g]) begin
                        if (WAKE_CYCLES == 0) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            state_d = WAKE;
                            wcnt_d  = '0;
                        end
                    end
                end
                WAKE: begin
                    // A wake always completes, even if activity has already gone away.
                    if (wcnt_q == WAKE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end
            endcase
        end

        assign clk_en_o[g]     = (state_q != OFF) | bypass_i;
        assign unit_ready_o[g] = (state_q == RUN);
        assign unit_gated_o[g] = (state_q == OFF);
    end

endmodule
